control_sequencer: RTL
======================

# control_sequencer

Hardwired control unit that replaces the hand-sequenced control stimulus used to drive `dataPath`. It decodes the opcode latched in IR and steps through T-states T0..T7. Each state asserts the datapath strobes (bus drivers, register loads, memory read/write, ALU control, GRA/GRB/GRC). It generalises the fixed fetch + ldi sequence to several instruction classes, parametrised widths, memory wait states, run/halt control and illegal-opcode detection.

## Interface
Parameters:
- IR_W, 32: instruction width.
- OPC_W, 5: opcode width; opcode = ir[IR_W-1 -: OPC_W].
- CTRL_W, 4: ALU control width.
- ALU_ADD, 4'd2: ALU code for add.
- ALU_SUB, 4'd3: ALU code for subtract.

Ports:
- clk  in  1  clock; the state register updates on the falling edge, so strobes are stable before the datapath's rising-edge capture.
- reset  in  1  asynchronous, active-high; forces IDLE.
- run  in  1  level; permits instruction fetch.
- ir  in  IR_W  IR contents from the datapath.
- mem_ready  in  1  memory handshake; high = access complete this cycle.
- PCout, Zlowout, MDRout, MARin, PCin, MDRin, IRin, Yin, IncPc, Zlowin, Cout, BAout, Rin, Rout, GRA, GRB, GRC, read, write  out  1 each  datapath strobes.
- mdr_read  out  2  MDR source select: 2'b01 = memory, 2'b00 = bus.
- control  out  CTRL_W  ALU operation.
- tstate  out  4  current state code: IDLE=15, T0..T7=0..7, HALT=14.
- halted  out  1  high in HALT.
- illegal  out  1  one-cycle pulse on an undefined opcode.

## Operation
- Outputs are Moore: a function of state and opcode (`opc`). `opc` is captured from `ir` on the T2 to T3 transition.
- Every strobe not listed for a state is 0. In every state, `control` = 0 and `mdr_read` = 2'b00 unless stated otherwise.
- Reset: state=IDLE, opc=0, all outputs 0, tstate=15.
- IDLE: if run, go to T0.
- Fetch, common to all instructions:
  - T0: PCout, MARin, IncPc, Zlowin.
  - T1: Zlowout, PCin, read, mdr_read=01, MDRin. Stay in T1 while mem_ready=0; PCin is asserted only on the first T1 cycle.
  - T2: MDRout, IRin.
- Opcodes and execute sequences:
  - ld = 0, ldi = 1, st = 2, add = 3, sub = 4, addi = 12, nop = 26, halt = 27.
  - ldi: T3 GRB, BAout, Yin; T4 Cout, control=ALU_ADD, Zlowin; T5 Zlowout, GRA, Rin; then T0.
  - addi: as ldi, but T3 uses Rout instead of BAout.
  - add/sub: T3 GRB, Rout, Yin; T4 GRC, Rout, control=ALU_ADD or ALU_SUB, Zlowin; T5 Zlowout, GRA, Rin.
  - ld: T3 and T4 as ldi; T5 Zlowout, MARin; T6 read, mdr_read=01, MDRin, holding while mem_ready=0; T7 MDRout, GRA, Rin.
  - st: T3 and T4 as ldi; T5 Zlowout, MARin; T6 GRA, Rout, mdr_read=00, MDRin; T7 MDRout, write, holding while mem_ready=0.
  - nop: T3, then T0.
  - halt: T3, then HALT. HALT is left only by reset.
  - Undefined opcode: `illegal` pulses in T3, then the nop path.
- End of instruction: the last execute state goes to T0 if run=1, otherwise to IDLE. Dropping run mid-instruction does not abort the instruction.

## Timing
- Fetch takes 3 cycles plus wait cycles. Total cycles with zero wait states:
  - nop: 4
  - ldi, addi, add, sub: 6
  - ld, st: 8
- Wait states:
  - Each cycle mem_ready=0 in T1 or T6(ld) or T7(st) adds one cycle.
  - The strobes of the holding state stay asserted throughout the wait.
  - mem_ready is ignored in every other state.
- Exactly one of {PCout, Zlowout, MDRout, Rout, BAout, Cout} is asserted per state, or none.
- Reset mid-instruction: outputs are 0 asynchronously, with no partial write. write deasserts immediately.
- `opc` holds from T3 until the next T2, so changes on `ir` outside T2 have no effect.

## Test plan
- Reset, run=1, ir=ldi opcode (32'h0800_0023), mem_ready=1:
  - sequence T0,T1,T2,T3,T4,T5 then T0;
  - control=2 only in T4;
  - GRA and Rin high only in T5.
- add then sub with run=1: control=2, then control=3 in the respective T4; GRC and Rout high in T4 each time.
- ld with mem_ready low for 3 cycles in T6: T6 persists for 4 cycles with read and MDRin steady, then T7 asserts MDRout, GRA, Rin.
- st with a 2-cycle wait in T7: write is held for 3 cycles; mdr_read=00 in T6.
- Opcode 5'd31: illegal pulses for 1 cycle in T3; returns to T0. Then halt: halted=1 and state frozen for 20 cycles; reset returns to IDLE.
- Asserting reset in T6 of ld: all outputs are 0 within the same cycle. Drop run at T4 of ldi: the instruction completes through T5, then IDLE.

Source files
------------

// File: rtl/control_sequencer.sv
// Hardwired control sequencer for dataPath: fetches, decodes the latched opcode and
// steps T0..T7, driving Moore strobes from a register updated on the falling clock edge.
module control_sequencer #(
    parameter int                IR_W    = 32,
    parameter int                OPC_W   = 5,
    parameter int                CTRL_W  = 4,
    parameter logic [CTRL_W-1:0] ALU_ADD = 4'd2,
    parameter logic [CTRL_W-1:0] ALU_SUB = 4'd3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [IR_W-1:0]   ir,
    input  logic              mem_ready,
    output logic              PCout,
    output logic              Zlowout,
    output logic              MDRout,
    output logic              MARin,
    output logic              PCin,
    output logic              MDRin,
    output logic              IRin,
    output logic              Yin,
    output logic              IncPc,
    output logic              Zlowin,
    output logic              Cout,
    output logic              BAout,
    output logic              Rin,
    output logic              Rout,
    output logic              GRA,
    output logic              GRB,
    output logic              GRC,
    output logic              read,
    output logic              write,
    output logic [1:0]        mdr_read,
    output logic [CTRL_W-1:0] control,
    output logic [3:0]        tstate,
    output logic              halted,
    output logic              illegal
);

    typedef enum logic [3:0] {
        S_T0   = 4'd0,
        S_T1   = 4'd1,
        S_T2   = 4'd2,
        S_T3   = 4'd3,
        S_T4   = 4'd4,
        S_T5   = 4'd5,
        S_T6   = 4'd6,
        S_T7   = 4'd7,
        S_HALT = 4'd14,
        S_IDLE = 4'd15
    } state_t;

    typedef struct packed {
        logic              pc_out;
        logic              zlow_out;
        logic              mdr_out;
        logic              mar_in;
        logic              pc_in;
        logic              mdr_in;
        logic              ir_in;
        logic              y_in;
        logic              inc_pc;
        logic              zlow_in;
        logic              c_out;
        logic              ba_out;
        logic              r_in;
        logic              r_out;
        logic              gra;
        logic              grb;
        logic              grc;
        logic              rd;
        logic              wr;
        logic [1:0]        mdr_sel;
        logic [CTRL_W-1:0] alu;
        logic              illegal;
        logic              halted;
    } ctrl_t;

    localparam logic [OPC_W-1:0] OP_LD   = OPC_W'(5'd0);
    localparam logic [OPC_W-1:0] OP_LDI  = OPC_W'(5'd1);
    localparam logic [OPC_W-1:0] OP_ST   = OPC_W'(5'd2);
    localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(5'd3);
    localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(5'd4);
    localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(5'd12);
    localparam logic [OPC_W-1:0] OP_NOP  = OPC_W'(5'd26);
    localparam logic [OPC_W-1:0] OP_HALT = OPC_W'(5'd27);

    state_t            state_r;
    state_t            next_state_s;
    state_t            end_state_s;
    logic [OPC_W-1:0]  opc_r;
    logic [OPC_W-1:0]  next_opc_s;
    logic              first_t1_s;
    ctrl_t             ctrl_r;
    ctrl_t             ctrl_next_s;
    logic              unused_ir_s;

    // Operand fields of IR are consumed by the datapath, not by the sequencer.
    assign unused_ir_s = ^ir[IR_W-OPC_W-1:0];

    // Strobe pattern for a given state; T1 asserts PCin only on entry so waits do not re-load PC.
    function automatic ctrl_t decode_f(input state_t st, input logic [OPC_W-1:0] op,
                                       input logic first);
        ctrl_t c;
        c = '0;
        case (st)
            S_T0: begin
                c.pc_out  = 1'b1;
                c.mar_in  = 1'b1;
                c.inc_pc  = 1'b1;
                c.zlow_in = 1'b1;
            end
            S_T1: begin
                c.zlow_out = 1'b1;
                c.pc_in    = first;
                c.rd       = 1'b1;
                c.mdr_sel  = 2'b01;
                c.mdr_in   = 1'b1;
            end
            S_T2: begin
                c.mdr_out = 1'b1;
                c.ir_in   = 1'b1;
            end
            S_T3: begin
                case (op)
                    OP_LD, OP_LDI, OP_ST: begin
                        c.grb    = 1'b1;
                        c.ba_out = 1'b1;
                        c.y_in   = 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_ADDI: begin
                        c.grb   = 1'b1;
                        c.r_out = 1'b1;
                        c.y_in  = 1'b1;
                    end
                    OP_NOP, OP_HALT: begin
                        c.illegal = 1'b0;
                    end
                    default: begin
                        c.illegal = 1'b1;
                    end
                endcase
            end
            S_T4: begin
                case (op)
                    OP_ADD, OP_SUB: begin
                        c.grc     = 1'b1;
                        c.r_out   = 1'b1;
                        c.zlow_in = 1'b1;
                        c.alu     = (op == OP_SUB) ? ALU_SUB : ALU_ADD;
                    end
                    OP_LD, OP_LDI, OP_ST, OP_ADDI: begin
                        c.c_out   = 1'b1;
                        c.zlow_in = 1'b1;
                        c.alu     = ALU_ADD;
                    end
                    default: begin
                        c.alu = '0;
                    end
                endcase
            end
            S_T5: begin
                case (op)
                    OP_LD, OP_ST: begin
                        c.zlow_out = 1'b1;
                        c.mar_in   = 1'b1;
                    end
                    OP_LDI, OP_ADDI, OP_ADD, OP_SUB: begin
                        c.zlow_out = 1'b1;
                        c.gra      = 1'b1;
                        c.r_in     = 1'b1;
                    end
                    default: begin
                        c.zlow_out = 1'b0;
                    end
                endcase
            end
            S_T6: begin
                case (op)
                    OP_LD: begin
                        c.rd      = 1'b1;
                        c.mdr_sel = 2'b01;
                        c.mdr_in  = 1'b1;
                    end
                    OP_ST: begin
                        c.gra    = 1'b1;
                        c.r_out  = 1'b1;
                        c.mdr_in = 1'b1;
                    end
                    default: begin
                        c.mdr_in = 1'b0;
                    end
                endcase
            end
            S_T7: begin
                case (op)
                    OP_LD: begin
                        c.mdr_out = 1'b1;
                        c.gra     = 1'b1;
                        c.r_in    = 1'b1;
                    end
                    OP_ST: begin
                        c.mdr_out = 1'b1;
                        c.wr      = 1'b1;
                    end
                    default: begin
                        c.mdr_out = 1'b0;
                    end
                endcase
            end
            S_HALT: begin
                c.halted = 1'b1;
            end
            default: begin
                c = '0;
            end
        endcase
        return c;
    endfunction

    // Next-state sequencing; the last execute state returns to T0 or IDLE depending on run.
    always_comb begin
        next_state_s = state_r;
        if (run) begin
            end_state_s = S_T0;
        end else begin
            end_state_s = S_IDLE;
        end
        case (state_r)
            S_IDLE: begin
                if (run) begin
                    next_state_s = S_T0;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_T0: next_state_s = S_T1;
            S_T1: begin
                if (mem_ready) begin
                    next_state_s = S_T2;
                end else begin
                    next_state_s = S_T1;
                end
            end
            S_T2: next_state_s = S_T3;
            S_T3: begin
                case (opc_r)
                    OP_HALT: next_state_s = S_HALT;
                    OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_ADDI: next_state_s = S_T4;
                    default: next_state_s = end_state_s;
                endcase
            end
            S_T4: next_state_s = S_T5;
            S_T5: begin
                if ((opc_r == OP_LD) || (opc_r == OP_ST)) begin
                    next_state_s = S_T6;
                end else begin
                    next_state_s = end_state_s;
                end
            end
            S_T6: begin
                if ((opc_r == OP_LD) && !mem_ready) begin
                    next_state_s = S_T6;
                end else begin
                    next_state_s = S_T7;
                end
            end
            S_T7: begin
                if ((opc_r == OP_ST) && !mem_ready) begin
                    next_state_s = S_T7;
                end else begin
                    next_state_s = end_state_s;
                end
            end
            S_HALT: next_state_s = S_HALT;
            default: next_state_s = S_IDLE;
        endcase
    end

    // Opcode capture on leaving T2 and decode of the strobes for the state being entered.
    always_comb begin
        if (state_r == S_T2) begin
            next_opc_s = ir[IR_W-1 -: OPC_W];
        end else begin
            next_opc_s = opc_r;
        end
        first_t1_s  = (state_r != S_T1);
        ctrl_next_s = decode_f(next_state_s, next_opc_s, first_t1_s);
    end

    // State, opcode and strobe registers; falling edge lets strobes settle before datapath capture.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
            opc_r   <= '0;
            ctrl_r  <= '0;
        end else begin
            state_r <= next_state_s;
            opc_r   <= next_opc_s;
            ctrl_r  <= ctrl_next_s;
        end
    end

    assign PCout    = ctrl_r.pc_out;
    assign Zlowout  = ctrl_r.zlow_out;
    assign MDRout   = ctrl_r.mdr_out;
    assign MARin    = ctrl_r.mar_in;
    assign PCin     = ctrl_r.pc_in;
    assign MDRin    = ctrl_r.mdr_in;
    assign IRin     = ctrl_r.ir_in;
    assign Yin      = ctrl_r.y_in;
    assign IncPc    = ctrl_r.inc_pc;
    assign Zlowin   = ctrl_r.zlow_in;
    assign Cout     = ctrl_r.c_out;
    assign BAout    = ctrl_r.ba_out;
    assign Rin      = ctrl_r.r_in;
    assign Rout     = ctrl_r.r_out;
    assign GRA      = ctrl_r.gra;
    assign GRB      = ctrl_r.grb;
    assign GRC      = ctrl_r.grc;
    assign read     = ctrl_r.rd;
    assign write    = ctrl_r.wr;
    assign mdr_read = ctrl_r.mdr_sel;
    assign control  = ctrl_r.alu;
    assign halted   = ctrl_r.halted;
    assign illegal  = ctrl_r.illegal;
    assign tstate   = state_r;

endmodule
